// File: rtl/fp_norm_round_pipe_if.sv
// fp_norm_round_pipe_if: handshake and data bundle for the normalise-and-round pipe
//   in_valid/in_ready  : input word handshake
//   in_cout, in_sig, in_grs, in_exp, in_sign, in_neg : raw adder result
//   out_valid/out_ready: result handshake
//   out_sig, out_exp, out_sign, out_zero, out_of, out_uf : rounded result and flags
//   master = producer/consumer side, slave = the pipe itself
interface fp_norm_round_pipe_if #(parameter int SIG_W = 24, parameter int EXP_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic             in_cout;
  logic [SIG_W-1:0] in_sig;
  logic [2:0]       in_grs;
  logic [EXP_W-1:0] in_exp;
  logic             in_sign;
  logic             in_neg;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] out_sig;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_of;
  logic             out_uf;
  modport master (
    output in_valid, in_cout, in_sig, in_grs, in_exp, in_sign, in_neg, out_ready,
    input  in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_of, out_uf
  );
  modport slave (
    input  in_valid, in_cout, in_sig, in_grs, in_exp, in_sign, in_neg, out_ready,
    output in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_of, out_uf
  );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: 3-stage valid/ready normalise and round-to-nearest-even stage
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   io    : fp_norm_round_pipe_if.slave (input word, result, flags, handshakes)
module fp_norm_round_pipe #(
  parameter int SIG_W = 24,
  parameter int EXP_W = 8
) (
  input logic clk,
  input logic rst_n,
  fp_norm_round_pipe_if.slave io
);
  localparam int W = SIG_W + 3;
  localparam int L = $clog2(W);
  localparam int P = 1 << L;
  localparam logic [L-1:0] ONE_L = {{(L-1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] ONE_E = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] MAX_E = {2'b00, {EXP_W{1'b1}}};
  logic v1, v2, v3;
  logic r1, r2, r3;
  logic [W-1:0] w1, w2;
  logic signed [EXP_W+1:0] e1, e2;
  logic g1, g2, z2, u2;
  logic [SIG_W-1:0] sig_q;
  logic [EXP_W-1:0] exp_q;
  logic sign_q, zero_q, of_q, uf_q;
  // Handshake chain: a stage can take a word when empty or when it empties this cycle.
  assign r3 = ~v3 | io.out_ready;
  assign r2 = ~v2 | r3;
  assign r1 = ~v1 | r2;
  assign io.in_ready  = r1;
  assign io.out_valid = v3;
  assign io.out_sig   = sig_q;
  assign io.out_exp   = exp_q;
  assign io.out_sign  = sign_q;
  assign io.out_zero  = zero_q;
  assign io.out_of    = of_q;
  assign io.out_uf    = uf_q;
  logic [SIG_W+3:0] wi, wn;
  logic [W-1:0] w1_n;
  logic signed [EXP_W+1:0] e1_n;
  assign wi = {io.in_cout, io.in_sig, io.in_grs};
  assign wn = io.in_neg ? ~wi + 1'b1 : wi;
  // A carry folds the dropped bit into sticky so rounding still sees it.
  assign w1_n = wn[SIG_W+3] ? {wn[SIG_W+3:2], wn[1] | wn[0]} : wn[SIG_W+2:0];
  assign e1_n = {2'b00, io.in_exp} + {{(EXP_W+1){1'b0}}, wn[SIG_W+3]};
  // Heap-ordered LZC tree; node n has children 2n (more significant) and 2n+1.
  // The word is left-aligned in a power-of-two field padded with zeros below,
  // so a nonzero word always finds its leading one inside its own bits.
  logic [P-1:0] pw;
  logic         v [1:2*P-1];
  logic [L-1:0] c [1:2*P-1];
  assign pw = P'(w1) << (P - W);
  for (genvar i = 0; i < P; i++) begin : g_leaf
    assign v[P+i] = pw[P-1-i];
    assign c[P+i] = '0;
  end
  for (genvar d = 0; d < L; d++) begin : g_lvl
    for (genvar i = 0; i < (1 << d); i++) begin : g_node
      localparam int N = (1 << d) + i;
      assign v[N] = v[2*N] | v[2*N+1];
      assign c[N] = v[2*N] ? c[2*N] : (c[2*N+1] | (ONE_L << (L - 1 - d)));
    end
  end
  logic zero2_n, uf2_n;
  logic signed [EXP_W+1:0] ez;
  logic [W-1:0] w2_n;
  assign zero2_n = ~v[1];
  assign ez      = e1 - {{(EXP_W+2-L){1'b0}}, c[1]};
  assign uf2_n   = ~zero2_n & (ez < ONE_E);
  assign w2_n    = w1 << c[1];
  logic up, kill, of;
  logic [SIG_W:0] rs;
  logic [SIG_W-1:0] sig3;
  logic signed [EXP_W+1:0] e3;
  always_comb begin
    up   = w2[2] & (w2[1] | w2[0] | w2[3]);
    rs   = {1'b0, w2[SIG_W+2:3]} + {{SIG_W{1'b0}}, up};
    e3   = e2 + {{(EXP_W+1){1'b0}}, rs[SIG_W]};
    sig3 = rs[SIG_W] ? rs[SIG_W:1] : rs[SIG_W-1:0];
    of   = e3 >= MAX_E;
    kill = z2 | u2;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      w1 <= '0;
      w2 <= '0;
      e1 <= '0;
      e2 <= '0;
      g1 <= 1'b0;
      g2 <= 1'b0;
      z2 <= 1'b0;
      u2 <= 1'b0;
      sig_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      if (r1) v1 <= io.in_valid;
      if (r1 & io.in_valid) begin
        w1 <= w1_n;
        e1 <= e1_n;
        g1 <= io.in_sign ^ io.in_neg;
      end
      if (r2) v2 <= v1;
      if (r2 & v1) begin
        w2 <= w2_n;
        e2 <= ez;
        g2 <= g1;
        z2 <= zero2_n;
        u2 <= uf2_n;
      end
      if (r3) v3 <= v2;
      if (r3 & v2) begin
        sig_q  <= kill ? '0 : of ? {1'b1, {(SIG_W-1){1'b0}}} : sig3;
        exp_q  <= kill ? '0 : of ? {EXP_W{1'b1}} : e3[EXP_W-1:0];
        sign_q <= ~kill & g2;
        zero_q <= z2;
        of_q   <= ~kill & of;
        uf_q   <= u2 & ~z2;
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe: directed self-checking bench for fp_norm_round_pipe
module tb_fp_norm_round_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fp_norm_round_pipe_if #(.SIG_W(24), .EXP_W(8)) bus();
  fp_norm_round_pipe #(.SIG_W(24), .EXP_W(8)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic put(input logic cout, input logic [23:0] sig, input logic [2:0] grs,
                     input logic [7:0] e, input logic sign, input logic neg);
    bus.in_cout = cout;
    bus.in_sig  = sig;
    bus.in_grs  = grs;
    bus.in_exp  = e;
    bus.in_sign = sign;
    bus.in_neg  = neg;
  endtask
  task automatic chk_out(input string tag, input logic [23:0] sig, input logic [7:0] e,
                         input logic sign, input logic z, input logic o, input logic u);
    chk({tag, ".sig"}, 64'(bus.out_sig), 64'(sig));
    chk({tag, ".exp"}, 64'(bus.out_exp), 64'(e));
    chk({tag, ".flags"}, 64'({bus.out_sign, bus.out_zero, bus.out_of, bus.out_uf}),
        64'({sign, z, o, u}));
  endtask
  task automatic vec(input string tag, input logic cout, input logic [23:0] sig,
                     input logic [2:0] grs, input logic [7:0] e, input logic sign,
                     input logic neg, input logic [23:0] xs, input logic [7:0] xe,
                     input logic xsign, input logic xz, input logic xo, input logic xu);
    @(negedge clk);
    put(cout, sig, grs, e, sign, neg);
    bus.in_valid = 1'b1;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    put(1'b0, 24'h0, 3'b0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, ".early"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk_out(tag, xs, xe, xsign, xz, xo, xu);
  endtask
  initial begin
    int sent, rcv;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    put(1'b0, 24'h0, 3'b0, 8'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk_out("rst", 24'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("carry",  1'b1, 24'h800000, 3'b000, 8'h7F, 1'b0, 1'b0, 24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("lz",     1'b0, 24'h000100, 3'b000, 8'h90, 1'b0, 1'b0, 24'h800000, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("uf",     1'b0, 24'h000001, 3'b000, 8'h10, 1'b0, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    vec("neg",    1'b1, 24'hFFFF00, 3'b000, 8'h90, 1'b0, 1'b1, 24'h800000, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    vec("zero",   1'b0, 24'h000000, 3'b000, 8'h55, 1'b1, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vec("tie",    1'b0, 24'h800000, 3'b100, 8'h7F, 1'b0, 1'b0, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("rup",    1'b0, 24'h800001, 3'b100, 8'h7F, 1'b0, 1'b0, 24'h800002, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("of",     1'b0, 24'hFFFFFF, 3'b100, 8'hFE, 1'b0, 1'b0, 24'h800000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    vec("rcarry", 1'b0, 24'hFFFFFF, 3'b110, 8'h7F, 1'b1, 1'b0, 24'h800000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    vec("stky",   1'b1, 24'h800001, 3'b100, 8'h7F, 1'b0, 1'b0, 24'hC00001, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sent = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc < 2 || cyc > 8);
      bus.in_valid  = (sent < 6);
      put(1'b0, 24'h800000 | 24'(sent), 3'b000, 8'h40 + 8'(sent), 1'b0, 1'b0);
      #1;
      if (cyc == 2) chk("bp.ready_hi", 64'(bus.in_ready), 64'd1);
      if (cyc == 3) chk("bp.ready_lo", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid) begin
        chk("bp.sig", 64'(bus.out_sig), 64'(24'h800000 | 24'(rcv)));
        chk("bp.exp", 64'(bus.out_exp), 64'(8'h40 + 8'(rcv)));
        if (bus.out_ready) rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    chk("bp.sent", 64'(sent), 64'd6);
    chk("bp.rcv", 64'(rcv), 64'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("bp.nodup", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      put(1'b0, 24'h800000 | 24'(k + 1), 3'b000, 8'h50, 1'b1, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst.valid", 64'(bus.out_valid), 64'd0);
    chk("mrst.in_ready", 64'(bus.in_ready), 64'd1);
    chk_out("mrst", 24'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mrst.quiet", 64'(bus.out_valid), 64'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_norm_round_pipe.md
# fp_norm_round_pipe

Parametrised, pipelined normalise-and-round stage for the Vector ALU floating-point add path. It takes the raw post-adder result and produces a normalised, IEEE-style round-to-nearest-even significand and exponent. Inputs are a carry-out, a significand with guard/round/sticky bits, a biased exponent, and an optional two's-complement "negative" flag. It also flags zero, overflow (saturate to infinity) and underflow (flush to zero). It is a 3-stage valid/ready pipeline that replaces the earlier combinational normaliser and sits between the significand adder and the VALU result register.

## Interface
- SIG_W, 24, significand width including the hidden bit (out_sig[SIG_W-1] is the hidden 1)
- EXP_W, 8, biased exponent width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  stage 1 can accept
- in_cout  in  1  adder carry-out
- in_sig  in  SIG_W  adder significand
- in_grs  in  3  guard, round, sticky
- in_exp  in  EXP_W  biased exponent of the operation
- in_sign  in  1  sign of the operation
- in_neg  in  1  {in_cout,in_sig,in_grs} is a negative two's-complement value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_sig  out  SIG_W  normalised, rounded significand
- out_exp  out  EXP_W  result exponent
- out_sign  out  1  result sign
- out_zero, out_of, out_uf  out  1 each  zero, overflow, underflow flags

## Operation
- Word W = {in_cout, in_sig, in_grs}, width SIG_W+4. Bit SIG_W+3 is the carry, bit SIG_W+2 is the significand MSB.
- Stage 1 (sign/carry):
  - If in_neg, W = (~W + 1) mod 2^(SIG_W+4) and sign = ~in_sign; otherwise sign = in_sign.
  - If W[SIG_W+3] is set, shift W right by 1 and OR the dropped bit into bit 0 (sticky), with exp = in_exp+1.
  - Otherwise exp = in_exp.
  - Exponent is carried internally as signed, EXP_W+2 bits.
- Stage 2 (leading-zero normalise):
  - If W[SIG_W+2:0]==0, the result is zero.
  - Otherwise z = leading-zero count of W[SIG_W+2:0] (0..SIG_W+2), computed by a parametrised tree LZC with no loop-based shifting.
  - If exp - z < 1, the result is underflow.
  - Otherwise shift W left by z (zeros shifted in) and set exp = exp - z.
- Stage 3 (round, exceptions):
  - lsb = W[3], G = W[2], S = W[1]|W[0]; round up iff G & (S | lsb).
  - The increment is SIG_W+1 bits wide. On carry, sig = 1 followed by zeros and exp = exp+1.
  - If exp ≥ 2^EXP_W−1: overflow. Output exp all ones, sig = 1 followed by zeros, out_of=1.
  - Zero: out_sig=0, out_exp=0, out_sign=0, out_zero=1.
  - Underflow: same outputs as zero, plus out_uf=1.
  - Flags are mutually exclusive.

## Timing
- Latency is 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when out_ready is held high. Throughput is 1 result per cycle.
- Each stage has a valid bit. A stage loads when it is empty or when its contents advance in the same cycle. out_valid = stage-3 valid.
- in_ready = ~s1_valid | s1_advance (combinational from out_ready through the chain). Bubbles collapse.
- With out_valid high and out_ready low, all outputs stay stable. Up to 3 words are held; no word is dropped, duplicated or reordered.
- Simultaneous accept and emit in the same cycle is allowed at full occupancy.
- Reset (rst_n low at a clock edge):
  - All stage valids are 0; out_valid=0 from the next edge.
  - All outputs are 0: out_sig, out_exp, out_sign, out_zero, out_of, out_uf.
  - in_ready=1 after reset.
  - Reset mid-stream discards all in-flight words.
- Inputs are sampled only on accept. Data inputs are don't-care when in_valid=0.

## Test plan
Defaults SIG_W=24, EXP_W=8, out_ready=1.
- Carry: cout=1, sig=0x800000, grs=000, exp=0x7F, neg=0 → 3 cycles later sig=0xC00000, exp=0x80, no flags.
- Leading zeros: cout=0, sig=0x000100, grs=000, exp=0x90 → sig=0x800000, exp=0x81. Same word with sig=0x000001, exp=0x10 → out_uf=1, sig=0, exp=0.
- Negate: neg=1, sign=0, cout=1, sig=0xFFFF00, grs=000, exp=0x90 → sig=0x800000, exp=0x81, sign=1. All-zero word → out_zero=1, sign=0.
- Rounding:
  - sig=0x800000, grs=100 → sig=0x800000 (tie, even kept).
  - sig=0x800001, grs=100 → sig=0x800002.
  - sig=0xFFFFFF, grs=100, exp=0xFE → out_of=1, exp=0xFF, sig=0x800000.
- Backpressure: stream 6 distinct words back to back with out_ready=0 for cycles 2–8.
  - in_ready drops once 3 words are held.
  - Outputs stay stable while stalled.
  - All 6 results appear in order with correct values and no duplicates.
- Reset mid-stream: rst_n=0 for 1 cycle with 3 words in flight → out_valid=0 and all outputs 0 next cycle, none of the 3 words emitted later, in_ready=1.
